button_conditioner: RTL and testbench
=====================================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, consecutive synchronized samples needed to accept a level change (minimum 2).
REQ-002 Parameter HOLD_CYCLES, default 50000000, cycles from accepted press until the button counts as held (minimum 2).
REQ-003 Parameter REPEAT_CYCLES, default 10000000, auto-repeat period while held (minimum 2).
REQ-004 CLOCK_50  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 btn_n  input  1  raw push-button: 1 = released, 0 = pressed; asynchronous and bouncing.
REQ-007 press_pulse  output  1  one-cycle strobe on each accepted press.
REQ-008 release_pulse  output  1  one-cycle strobe on each accepted release.
REQ-009 toggle_state  output  1  level that inverts on every press_pulse.
REQ-010 held  output  1  high while the button is held past HOLD_CYCLES.
REQ-011 repeat_pulse  output  1  one-cycle strobe, first at hold, then every REPEAT_CYCLES while held.

Function
REQ-012 btn_n SHALL pass through a 2-flop synchronizer; the second flop output is "sync"; no other logic uses btn_n.
REQ-013 The FSM SHALL have the states IDLE, PRESS_WAIT, PRESSED, HELD and RELEASE_WAIT.
REQ-014 IDLE: sync=0 -> PRESS_WAIT with debounce count 1; otherwise stay.
REQ-015 PRESS_WAIT: sync=1 -> IDLE with count cleared; sync=0 and count reaching DEBOUNCE_CYCLES -> PRESSED with press_pulse=1 and toggle_state inverted.
REQ-016 Latency: btn_n first sampled low at edge N and held low SHALL give press_pulse high in the cycle after edge N+1+DEBOUNCE_CYCLES.
REQ-017 PRESSED: the hold counter increments each cycle; at HOLD_CYCLES -> HELD with held=1 and repeat_pulse=1 in the same cycle.
REQ-018 HELD: repeat_pulse SHALL assert for one cycle every REPEAT_CYCLES cycles after the previous repeat_pulse.
REQ-019 PRESSED or HELD with sync=1 -> RELEASE_WAIT with debounce count 1; the hold and repeat counters freeze.
REQ-020 RELEASE_WAIT: sync=1 and count reaching DEBOUNCE_CYCLES -> IDLE with release_pulse=1, held=0 and all counters cleared.
REQ-021 RELEASE_WAIT with sync=0 (bounce) -> return to HELD if held=1, else PRESSED, with frozen counters resuming; no pulse is issued.
REQ-022 press_pulse, release_pulse and repeat_pulse SHALL never be high for two consecutive cycles; press_pulse and release_pulse SHALL never coincide.
REQ-023 Counter widths SHALL be $clog2(parameter+1); counters saturate and never wrap.
REQ-024 Bounce shorter than DEBOUNCE_CYCLES consecutive samples SHALL produce no output change.
REQ-025 All outputs SHALL be registered.

Reset
REQ-026 Reset SHALL force IDLE, synchronizer flops to 1, all counters to 0, and every output to 0 (toggle_state=0).
REQ-027 Reset asserted mid-press SHALL discard the press without release_pulse; a button still low after reset deasserts SHALL be re-debounced as a new press.
REQ-028 The first rising clock edge after reset deassertion SHALL already sample btn_n normally.

Structure
REQ-029 The state encoding and the default parameter constants SHALL live in the shared package btn_pkg.
REQ-030 The synchronizer SHALL be the single sub-module sync_2ff (1-bit, reset value parameter).
REQ-031 The debounce counter SHALL be shared between PRESS_WAIT and RELEASE_WAIT; the hold and repeat counters are separate.

Verification (DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8, 20 ns clock)
REQ-032 Clean press: btn_n 1->0 sampled at edge 10, held low -> press_pulse only in the cycle after edge 15; toggle_state 0->1.
REQ-033 Bounce: btn_n low for 3 cycles, high for 1, low for 3, then high -> no press_pulse; toggle_state stays 0.
REQ-034 Hold: btn_n low for 60 cycles -> held rises 20 cycles after press_pulse, with repeat_pulse then and every 8 cycles; release gives release_pulse 5 cycles after btn_n rises, with held=0.
REQ-035 Release bounce: while held, btn_n high for 2 cycles then low -> no release_pulse; held stays 1; repeat spacing resumes with the frozen count.
REQ-036 Reset mid-press: reset_n pulsed low in PRESSED with btn_n low -> all outputs 0 at once; press_pulse again 5 cycles after reset release.
REQ-037 Two presses separated by a clean release -> toggle_state returns to 0; exactly 2 press_pulses and 2 release_pulses.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioner: FSM state encoding and
// default timing constants (in clock cycles).
package btn_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = 500000;
    localparam int unsigned HOLD_CYCLES_DEF     = 50000000;
    localparam int unsigned REPEAT_CYCLES_DEF   = 10000000;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_PRESS_WAIT   = 3'd1,
        ST_PRESSED      = 3'd2,
        ST_HELD         = 3'd3,
        ST_RELEASE_WAIT = 3'd4
    } btn_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
// Ports: clk, rst_n (async active-low), din (async input), dout (synchronized).
// RESET_VAL sets the value both flops take during reset.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic meta_q;
    logic sync_q;

    // Metastability filter: first flop may go metastable, second resolves it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
        end
    end

    assign dout = sync_q;

endmodule

// File: rtl/button_conditioner.sv
// Push-button conditioner: synchronizes and debounces an active-low button,
// then produces press/release strobes, a toggle level, a held level and an
// auto-repeat strobe while held.
// Ports: CLOCK_50 (clock), reset_n (async active-low), btn_n (raw button,
// 0 = pressed); outputs press_pulse, release_pulse, toggle_state, held,
// repeat_pulse, all registered.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned HOLD_CYCLES     = HOLD_CYCLES_DEF,
    parameter int unsigned REPEAT_CYCLES   = REPEAT_CYCLES_DEF
) (
    input  logic CLOCK_50,
    input  logic reset_n,
    input  logic btn_n,
    output logic press_pulse,
    output logic release_pulse,
    output logic toggle_state,
    output logic held,
    output logic repeat_pulse
);

    localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned REP_W = $clog2(REPEAT_CYCLES + 1);

    localparam logic [DB_W-1:0]  DB_MAX  = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [HLD_W-1:0] HLD_MAX = HLD_W'(HOLD_CYCLES);
    localparam logic [REP_W-1:0] REP_MAX = REP_W'(REPEAT_CYCLES);

    logic sync;

    btn_state_e       state_q, state_d;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d, db_inc;
    logic [HLD_W-1:0] hold_cnt_q, hold_cnt_d, hold_inc;
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d, rep_inc;

    logic press_pulse_q, press_pulse_d;
    logic release_pulse_q, release_pulse_d;
    logic toggle_state_q, toggle_state_d;
    logic held_q, held_d;
    logic repeat_pulse_q, repeat_pulse_d;

    // Idle level of the button is released (1), so sync resets high.
    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (CLOCK_50),
        .rst_n (reset_n),
        .din   (btn_n),
        .dout  (sync)
    );

    // State and counter register.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            db_cnt_q   <= '0;
            hold_cnt_q <= '0;
            rep_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            db_cnt_q   <= db_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            rep_cnt_q  <= rep_cnt_d;
        end
    end

    // Next state and counter updates; counters saturate at their limits.
    always_comb begin
        state_d    = state_q;
        db_cnt_d   = db_cnt_q;
        hold_cnt_d = hold_cnt_q;
        rep_cnt_d  = rep_cnt_q;
        db_inc     = (db_cnt_q == DB_MAX)    ? db_cnt_q   : db_cnt_q + DB_W'(1);
        hold_inc   = (hold_cnt_q == HLD_MAX) ? hold_cnt_q : hold_cnt_q + HLD_W'(1);
        rep_inc    = (rep_cnt_q == REP_MAX)  ? rep_cnt_q  : rep_cnt_q + REP_W'(1);

        case (state_q)
            ST_IDLE: begin
                if (!sync) begin
                    state_d  = ST_PRESS_WAIT;
                    db_cnt_d = DB_W'(1);
                end
            end
            ST_PRESS_WAIT: begin
                if (sync) begin
                    state_d  = ST_IDLE;
                    db_cnt_d = '0;
                end else if (db_inc == DB_MAX) begin
                    state_d    = ST_PRESSED;
                    db_cnt_d   = '0;
                    hold_cnt_d = '0;
                    rep_cnt_d  = '0;
                end else begin
                    db_cnt_d = db_inc;
                end
            end
            ST_PRESSED: begin
                // A release sample freezes the hold count until debounced.
                if (sync) begin
                    state_d  = ST_RELEASE_WAIT;
                    db_cnt_d = DB_W'(1);
                end else if (hold_inc == HLD_MAX) begin
                    state_d    = ST_HELD;
                    hold_cnt_d = hold_inc;
                    rep_cnt_d  = '0;
                end else begin
                    hold_cnt_d = hold_inc;
                end
            end
            ST_HELD: begin
                if (sync) begin
                    state_d  = ST_RELEASE_WAIT;
                    db_cnt_d = DB_W'(1);
                end else if (rep_inc == REP_MAX) begin
                    rep_cnt_d = '0;
                end else begin
                    rep_cnt_d = rep_inc;
                end
            end
            ST_RELEASE_WAIT: begin
                // Bounce back to the pressed side keeps the frozen counts.
                if (!sync) begin
                    state_d  = held_q ? ST_HELD : ST_PRESSED;
                    db_cnt_d = '0;
                end else if (db_inc == DB_MAX) begin
                    state_d    = ST_IDLE;
                    db_cnt_d   = '0;
                    hold_cnt_d = '0;
                    rep_cnt_d  = '0;
                end else begin
                    db_cnt_d = db_inc;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                db_cnt_d   = '0;
                hold_cnt_d = '0;
                rep_cnt_d  = '0;
            end
        endcase
    end

    // Output next values derived from the transition being taken.
    always_comb begin
        press_pulse_d   = (state_q == ST_PRESS_WAIT) && (state_d == ST_PRESSED);
        release_pulse_d = (state_q == ST_RELEASE_WAIT) && (state_d == ST_IDLE);
        repeat_pulse_d  = ((state_q == ST_PRESSED) && (state_d == ST_HELD)) ||
                          ((state_q == ST_HELD) && !sync && (rep_inc == REP_MAX));
        held_d          = (state_d == ST_HELD) ||
                          ((state_d == ST_RELEASE_WAIT) && held_q);
        toggle_state_d  = toggle_state_q ^ press_pulse_d;
    end

    // Output register.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            toggle_state_q  <= 1'b0;
            held_q          <= 1'b0;
            repeat_pulse_q  <= 1'b0;
        end else begin
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
            toggle_state_q  <= toggle_state_d;
            held_q          <= held_d;
            repeat_pulse_q  <= repeat_pulse_d;
        end
    end

    assign press_pulse   = press_pulse_q;
    assign release_pulse = release_pulse_q;
    assign toggle_state  = toggle_state_q;
    assign held          = held_q;
    assign repeat_pulse  = repeat_pulse_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE=4, HOLD=20, REPEAT=8.
// Inputs change on the falling edge; outputs are logged 1 ns after each rising
// edge tagged with the rising-edge count, so a value driven when cyc==c is
// first sampled at edge c+1 and a debounced press appears at cyc==c+6.
module tb_button_conditioner;

    logic clk;
    logic reset_n;
    logic btn_n;
    logic press_pulse;
    logic release_pulse;
    logic toggle_state;
    logic held;
    logic repeat_pulse;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int viol  = 0;

    int press_q[$];
    int release_q[$];
    int repeat_q[$];
    int held_rise_q[$];

    logic press_prev   = 1'b0;
    logic release_prev = 1'b0;
    logic repeat_prev  = 1'b0;
    logic held_prev    = 1'b0;

    button_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .HOLD_CYCLES     (20),
        .REPEAT_CYCLES   (8)
    ) dut (
        .CLOCK_50      (clk),
        .reset_n       (reset_n),
        .btn_n         (btn_n),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .toggle_state  (toggle_state),
        .held          (held),
        .repeat_pulse  (repeat_pulse)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Event logger and pulse-shape watcher.
    always begin
        @(posedge clk);
        #1;
        if (press_pulse)         press_q.push_back(cyc);
        if (release_pulse)       release_q.push_back(cyc);
        if (repeat_pulse)        repeat_q.push_back(cyc);
        if (held && !held_prev)  held_rise_q.push_back(cyc);
        if ((press_pulse && press_prev) || (release_pulse && release_prev) ||
            (repeat_pulse && repeat_prev) || (press_pulse && release_pulse))
            viol = viol + 1;
        press_prev   = press_pulse;
        release_prev = release_pulse;
        repeat_prev  = repeat_pulse;
        held_prev    = held;
    end

    task automatic clear_logs();
        press_q.delete();
        release_q.delete();
        repeat_q.delete();
        held_rise_q.delete();
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        btn_n   = 1'b1;
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        total += 5;
        if (press_pulse !== 1'b0)   begin bad++; $display("FAIL reset_press got %b want 0", press_pulse); end
        if (release_pulse !== 1'b0) begin bad++; $display("FAIL reset_release got %b want 0", release_pulse); end
        if (toggle_state !== 1'b0)  begin bad++; $display("FAIL reset_toggle got %b want 0", toggle_state); end
        if (held !== 1'b0)          begin bad++; $display("FAIL reset_held got %b want 0", held); end
        if (repeat_pulse !== 1'b0)  begin bad++; $display("FAIL reset_repeat got %b want 0", repeat_pulse); end
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        clear_logs();
    endtask

    task automatic test_bounce();
        clear_logs();
        btn_n = 1'b0; repeat (3) @(negedge clk);
        btn_n = 1'b1; repeat (1) @(negedge clk);
        btn_n = 1'b0; repeat (3) @(negedge clk);
        btn_n = 1'b1; repeat (15) @(negedge clk);
        total += 3;
        if (press_q.size() != 0)   begin bad++; $display("FAIL bounce_press_count got %0d want 0", press_q.size()); end
        if (release_q.size() != 0) begin bad++; $display("FAIL bounce_release_count got %0d want 0", release_q.size()); end
        if (toggle_state !== 1'b0) begin bad++; $display("FAIL bounce_toggle got %b want 0", toggle_state); end
    endtask

    task automatic test_clean_press();
        int c;
        int cr;
        clear_logs();
        c = cyc;
        btn_n = 1'b0;
        repeat (8) @(negedge clk);
        total += 2;
        if (press_q.size() != 1 || press_q[0] != c + 6) begin
            bad++;
            $display("FAIL clean_press_time got n=%0d first=%0d want n=1 at %0d",
                     press_q.size(), (press_q.size() > 0) ? press_q[0] : -1, c + 6);
        end
        if (toggle_state !== 1'b1) begin bad++; $display("FAIL clean_toggle got %b want 1", toggle_state); end
        cr = cyc;
        btn_n = 1'b1;
        repeat (10) @(negedge clk);
        total += 4;
        if (release_q.size() != 1 || release_q[0] != cr + 6) begin
            bad++;
            $display("FAIL clean_release_time got n=%0d first=%0d want n=1 at %0d",
                     release_q.size(), (release_q.size() > 0) ? release_q[0] : -1, cr + 6);
        end
        if (held_rise_q.size() != 0) begin bad++; $display("FAIL clean_no_held got %0d rises want 0", held_rise_q.size()); end
        if (repeat_q.size() != 0)    begin bad++; $display("FAIL clean_no_repeat got %0d want 0", repeat_q.size()); end
        if (toggle_state !== 1'b1)   begin bad++; $display("FAIL clean_toggle_after got %b want 1", toggle_state); end
    endtask

    task automatic test_hold();
        int c;
        int exp_rep[5];
        clear_logs();
        c = cyc;
        exp_rep[0] = c + 26; exp_rep[1] = c + 34; exp_rep[2] = c + 42;
        exp_rep[3] = c + 50; exp_rep[4] = c + 58;
        btn_n = 1'b0;
        repeat (60) @(negedge clk);
        btn_n = 1'b1;
        repeat (12) @(negedge clk);
        total += 6;
        if (press_q.size() != 1 || press_q[0] != c + 6) begin
            bad++; $display("FAIL hold_press_time got n=%0d want n=1 at %0d", press_q.size(), c + 6);
        end
        if (held_rise_q.size() != 1 || held_rise_q[0] != c + 26) begin
            bad++;
            $display("FAIL hold_held_rise got n=%0d first=%0d want n=1 at %0d",
                     held_rise_q.size(), (held_rise_q.size() > 0) ? held_rise_q[0] : -1, c + 26);
        end
        if (repeat_q.size() != 5) begin
            bad++; $display("FAIL hold_repeat_count got %0d want 5", repeat_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (repeat_q[i] != exp_rep[i]) begin
                    bad++; $display("FAIL hold_repeat_time[%0d] got %0d want %0d", i, repeat_q[i], exp_rep[i]);
                end
            end
        end
        if (release_q.size() != 1 || release_q[0] != c + 66) begin
            bad++;
            $display("FAIL hold_release_time got n=%0d first=%0d want n=1 at %0d",
                     release_q.size(), (release_q.size() > 0) ? release_q[0] : -1, c + 66);
        end
        if (held !== 1'b0)         begin bad++; $display("FAIL hold_held_after got %b want 0", held); end
        if (toggle_state !== 1'b0) begin bad++; $display("FAIL hold_toggle got %b want 0", toggle_state); end
    endtask

    task automatic test_release_bounce();
        int c;
        int exp_rep[4];
        clear_logs();
        c = cyc;
        // Three frozen cycles push the third repeat from c+42 to c+45.
        exp_rep[0] = c + 26; exp_rep[1] = c + 34; exp_rep[2] = c + 45; exp_rep[3] = c + 53;
        btn_n = 1'b0;
        repeat (36) @(negedge clk);
        btn_n = 1'b1;
        repeat (2) @(negedge clk);
        btn_n = 1'b0;
        repeat (6) @(negedge clk);
        total += 2;
        if (held !== 1'b1) begin bad++; $display("FAIL rb_held_kept got %b want 1", held); end
        if (release_q.size() != 0) begin bad++; $display("FAIL rb_no_release got %0d want 0", release_q.size()); end
        repeat (10) @(negedge clk);
        btn_n = 1'b1;
        repeat (12) @(negedge clk);
        total += 4;
        if (repeat_q.size() != 4) begin
            bad++; $display("FAIL rb_repeat_count got %0d want 4", repeat_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (repeat_q[i] != exp_rep[i]) begin
                    bad++; $display("FAIL rb_repeat_time[%0d] got %0d want %0d", i, repeat_q[i], exp_rep[i]);
                end
            end
        end
        if (release_q.size() != 1 || release_q[0] != c + 60) begin
            bad++;
            $display("FAIL rb_release_time got n=%0d first=%0d want n=1 at %0d",
                     release_q.size(), (release_q.size() > 0) ? release_q[0] : -1, c + 60);
        end
        if (held_rise_q.size() != 1) begin bad++; $display("FAIL rb_held_rises got %0d want 1", held_rise_q.size()); end
        if (toggle_state !== 1'b1)   begin bad++; $display("FAIL rb_toggle got %b want 1", toggle_state); end
    endtask

    task automatic test_reset_mid_press();
        int r;
        clear_logs();
        btn_n = 1'b0;
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        #1;
        total += 5;
        if (press_pulse !== 1'b0)   begin bad++; $display("FAIL rmp_press got %b want 0", press_pulse); end
        if (release_pulse !== 1'b0) begin bad++; $display("FAIL rmp_release got %b want 0", release_pulse); end
        if (toggle_state !== 1'b0)  begin bad++; $display("FAIL rmp_toggle got %b want 0", toggle_state); end
        if (held !== 1'b0)          begin bad++; $display("FAIL rmp_held got %b want 0", held); end
        if (repeat_pulse !== 1'b0)  begin bad++; $display("FAIL rmp_repeat got %b want 0", repeat_pulse); end
        repeat (2) @(negedge clk);
        clear_logs();
        r = cyc;
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        total += 3;
        if (press_q.size() != 1 || press_q[0] != r + 6) begin
            bad++;
            $display("FAIL rmp_repress_time got n=%0d first=%0d want n=1 at %0d",
                     press_q.size(), (press_q.size() > 0) ? press_q[0] : -1, r + 6);
        end
        if (release_q.size() != 0) begin bad++; $display("FAIL rmp_no_release got %0d want 0", release_q.size()); end
        if (toggle_state !== 1'b1) begin bad++; $display("FAIL rmp_toggle_after got %b want 1", toggle_state); end
        btn_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_two_presses();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        clear_logs();
        for (int k = 0; k < 2; k++) begin
            btn_n = 1'b0;
            repeat (8) @(negedge clk);
            btn_n = 1'b1;
            repeat (10) @(negedge clk);
        end
        total += 4;
        if (press_q.size() != 2)     begin bad++; $display("FAIL two_press_count got %0d want 2", press_q.size()); end
        if (release_q.size() != 2)   begin bad++; $display("FAIL two_release_count got %0d want 2", release_q.size()); end
        if (toggle_state !== 1'b0)   begin bad++; $display("FAIL two_toggle got %b want 0", toggle_state); end
        if (held_rise_q.size() != 0) begin bad++; $display("FAIL two_no_held got %0d want 0", held_rise_q.size()); end
    endtask

    task automatic test_pulse_rules();
        total += 1;
        if (viol != 0) begin bad++; $display("FAIL pulse_rules got %0d violations want 0", viol); end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_clean_press();
        test_hold();
        test_release_bounce();
        test_reset_mid_press();
        test_two_presses();
        test_pulse_rules();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
